// File: rtl/layer_mac_sequencer_pkg.sv
// Shared widths, types and the requantize/saturate helper for the fully-connected layer sequencer.
package nn_pkg;

    localparam int N_NEURONS = 20;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 10;
    localparam int FRAC_BITS = 8;
    localparam int ACC_W     = 40;
    localparam int PROD_W    = 2 * DATA_W;
    localparam int LANE_W    = $clog2(N_NEURONS);

    typedef logic signed [DATA_W-1:0] word_t;
    typedef logic        [ADDR_W-1:0] addr_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic        [LANE_W-1:0] lane_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAC   = 3'd1,
        BIAS  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    // Q16.16 accumulator -> Q8.8 word: arithmetic shift (floor), then clamp to the word range
    function automatic word_t requant(input acc_t acc);
        acc_t                     shifted;
        logic [ACC_W-DATA_W:0]    head;
        shifted = acc >>> FRAC_BITS;
        head    = shifted[ACC_W-1:DATA_W-1];
        if ((head == {(ACC_W-DATA_W+1){1'b0}}) || (head == {(ACC_W-DATA_W+1){1'b1}})) begin
            return shifted[DATA_W-1:0];
        end else if (shifted[ACC_W-1]) begin
            return {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            return {1'b0, {(DATA_W-1){1'b1}}};
        end
    endfunction

endpackage

// File: rtl/layer_mac_sequencer_if.sv
// Start/configuration, weight-bank and I/O RAM bus of the layer sequencer.
interface layer_mac_sequencer_if;
    import nn_pkg::*;

    logic                   start;
    addr_t                  n_inputs;
    addr_t                  in_base;
    addr_t                  out_base;
    addr_t                  w_base;
    addr_t [N_NEURONS-1:0]  wt_addr;
    word_t [N_NEURONS-1:0]  wt_q;
    addr_t                  io_addr;
    word_t                  io_d;
    logic                   io_wren;
    word_t                  io_q;
    logic                   busy;
    logic                   done;

    modport master (
        input  start, n_inputs, in_base, out_base, w_base, wt_q, io_q,
        output wt_addr, io_addr, io_d, io_wren, busy, done
    );

    modport slave (
        output start, n_inputs, in_base, out_base, w_base, wt_q, io_q,
        input  wt_addr, io_addr, io_d, io_wren, busy, done
    );

endinterface

// File: rtl/layer_mac_sequencer_mac.sv
// One neuron lane: Q8.8 multiply-accumulate, bias add, requantize/saturate.
// Build option RELU_EN clamps negative results to zero.
module mac_lane
    import nn_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  mac_en,
    input  logic  bias_en,
    input  word_t x,
    input  word_t w,
    output word_t res
);
    logic signed [PROD_W-1:0] prod_s;
    acc_t                     bias_s;
    acc_t                     acc_next_s;
    acc_t                     acc_r;
    word_t                    sat_s;
    word_t                    res_next_s;
    word_t                    res_r;

    // Next accumulator value: clear at start, add product during MAC, add Q16.16 bias
    always_comb begin
        prod_s     = PROD_W'(x) * PROD_W'(w);
        bias_s     = {{(ACC_W-DATA_W-FRAC_BITS){w[DATA_W-1]}}, w, {FRAC_BITS{1'b0}}};
        acc_next_s = acc_r;
        if (clr) begin
            acc_next_s = {ACC_W{1'b0}};
        end else if (mac_en) begin
            acc_next_s = acc_r + {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
        end else if (bias_en) begin
            acc_next_s = acc_r + bias_s;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Requantize the next accumulator so the registered result always tracks acc_r
    always_comb begin
        sat_s = requant(acc_next_s);
`ifdef RELU_EN
        if (sat_s[DATA_W-1]) begin
            res_next_s = {DATA_W{1'b0}};
        end else begin
            res_next_s = sat_s;
        end
`else
        res_next_s = sat_s;
`endif
    end

    // Accumulator and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= {ACC_W{1'b0}};
            res_r <= {DATA_W{1'b0}};
        end else begin
            acc_r <= acc_next_s;
            res_r <= res_next_s;
        end
    end

    assign res = res_r;

endmodule

// File: rtl/layer_mac_sequencer.sv
// Fully-connected layer sequencer: streams inputs and weights into 20 MAC lanes, then writes results back.
// Build option RELU_EN (applied inside mac_lane) selects ReLU output layers.
module layer_mac_sequencer
    import nn_pkg::*;
(
    input logic                   clk,
    input logic                   rst,
    layer_mac_sequencer_if.master bus
);
    localparam logic [2:0] ST_IDLE  = 3'(IDLE);
    localparam logic [2:0] ST_MAC   = 3'(MAC);
    localparam logic [2:0] ST_BIAS  = 3'(BIAS);
    localparam logic [2:0] ST_WRITE = 3'(WRITE);
    localparam logic [2:0] ST_DONE  = 3'(DONE);
    localparam lane_t      LAST_K   = lane_t'(N_NEURONS - 1);
    localparam addr_t      ADDR_ONE = addr_t'(1'b1);
    localparam lane_t      LANE_ONE = lane_t'(1'b1);

    logic [2:0] state_r;
    addr_t      c_r;
    lane_t      k_r;
    addr_t      n_r;
    addr_t      in_base_r;
    addr_t      out_base_r;
    addr_t      w_base_r;
    addr_t      wt_addr_r;
    addr_t      io_addr_r;
    logic       io_wren_r;
    logic       busy_r;
    logic       done_r;
    addr_t      c_inc_s;
    lane_t      k_inc_s;
    logic       clr_s;
    logic       mac_en_s;
    logic       bias_en_s;
    word_t      io_d_s;
    word_t      lane_res_s [N_NEURONS];

    // Lane controls, counter increments and the write-data mux
    always_comb begin
        c_inc_s   = c_r + ADDR_ONE;
        k_inc_s   = k_r + LANE_ONE;
        clr_s     = (state_r == ST_IDLE) && bus.start;
        mac_en_s  = (state_r == ST_MAC) && (c_r != {ADDR_W{1'b0}});
        bias_en_s = (state_r == ST_BIAS);
        if (state_r == ST_WRITE) begin
            io_d_s = lane_res_s[k_r];
        end else begin
            io_d_s = {DATA_W{1'b0}};
        end
    end

    // Sequencer FSM; addresses are registered on the edge that enters the cycle using them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            c_r        <= {ADDR_W{1'b0}};
            k_r        <= {LANE_W{1'b0}};
            n_r        <= {ADDR_W{1'b0}};
            in_base_r  <= {ADDR_W{1'b0}};
            out_base_r <= {ADDR_W{1'b0}};
            w_base_r   <= {ADDR_W{1'b0}};
            wt_addr_r  <= {ADDR_W{1'b0}};
            io_addr_r  <= {ADDR_W{1'b0}};
            io_wren_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_r    <= ST_MAC;
                        c_r        <= {ADDR_W{1'b0}};
                        n_r        <= bus.n_inputs;
                        in_base_r  <= bus.in_base;
                        out_base_r <= bus.out_base;
                        w_base_r   <= bus.w_base;
                        io_addr_r  <= bus.in_base;
                        wt_addr_r  <= bus.w_base;
                        busy_r     <= 1'b1;
                    end
                end
                ST_MAC: begin
                    // Last MAC cycle has already issued the bias slot W_Base+N_Inputs
                    if (c_r == n_r) begin
                        state_r <= ST_BIAS;
                    end else begin
                        c_r       <= c_inc_s;
                        io_addr_r <= in_base_r + c_inc_s;
                        wt_addr_r <= w_base_r + c_inc_s;
                    end
                end
                ST_BIAS: begin
                    state_r   <= ST_WRITE;
                    k_r       <= {LANE_W{1'b0}};
                    io_wren_r <= 1'b1;
                    io_addr_r <= out_base_r;
                    wt_addr_r <= {ADDR_W{1'b0}};
                end
                ST_WRITE: begin
                    if (k_r == LAST_K) begin
                        state_r   <= ST_DONE;
                        io_wren_r <= 1'b0;
                        io_addr_r <= {ADDR_W{1'b0}};
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                    end else begin
                        k_r       <= k_inc_s;
                        io_addr_r <= out_base_r + addr_t'(k_inc_s);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    io_wren_r <= 1'b0;
                    busy_r    <= 1'b0;
                    wt_addr_r <= {ADDR_W{1'b0}};
                end
            endcase
        end
    end

    for (genvar n = 0; n < N_NEURONS; n++) begin : g_lane
        mac_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .clr     (clr_s),
            .mac_en  (mac_en_s),
            .bias_en (bias_en_s),
            .x       (bus.io_q),
            .w       (bus.wt_q[n]),
            .res     (lane_res_s[n])
        );
    end

    assign bus.wt_addr = {N_NEURONS{wt_addr_r}};
    assign bus.io_addr = io_addr_r;
    assign bus.io_d    = io_d_s;
    assign bus.io_wren = io_wren_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;

endmodule
